// File: rtl/sync_word_qualifier.sv
// sync_word_qualifier
// Slow-domain stage behind the fast_to_slow synchronizer. A multi-bit bus that
// has just crossed domains may show a mix of old and new bits for a cycle, so a
// value is only accepted once it has been sampled unchanged on STABLE_CYCLES+1
// consecutive edges. Each distinct accepted word is pushed once into a small
// first-word-fall-through FIFO with a valid/ready handshake towards the
// consumer. All outputs are driven straight from registers.
module sync_word_qualifier #(
  parameter int S             = 12,
  parameter int STABLE_CYCLES = 2,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [S-1:0]           sync_data,
  output logic [S-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clear_overflow,
  output logic                   overflow,
  output logic [CNT_W-1:0]       word_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  // Widths of the stability counter, FIFO pointers and FIFO level.
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // The counter saturates at STABLE_CYCLES; a qualify event fires on the edge
  // that sees the run counter one below that value together with a match.
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_QUAL = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [S-1:0]     prev_r;
  logic [RUN_W-1:0] run_r;
  logic             have_last_r;
  logic [S-1:0]     last_val_r;

  logic [S-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [LVL_W-1:0] level_r;

  logic [S-1:0]     out_data_r;
  logic             out_valid_r;
  logic             overflow_r;
  logic [CNT_W-1:0] word_count_r;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic             match_s;
  logic             qualify_s;
  logic             wr_req_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             wr_en_s;
  logic             drop_s;
  logic [RUN_W-1:0] run_next_s;
  logic [LVL_W-1:0] level_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [S-1:0]     head_next_s;
  logic             overflow_next_s;

  // Stability tracking: compare against last edge's sample and count the run.
  always_comb begin
    match_s    = (sync_data == prev_r);
    run_next_s = run_r;
    if (!match_s) begin
      run_next_s = {RUN_W{1'b0}};
    end else if (run_r < RUN_MAX) begin
      run_next_s = run_r + RUN_ONE;
    end else begin
      run_next_s = run_r;
    end
    qualify_s = match_s && (run_r == RUN_QUAL);
  end

  // Dedup and FIFO handshake: decide write, pop and drop for this edge.
  always_comb begin
    wr_req_s = 1'b0;
    if (qualify_s) begin
      wr_req_s = !have_last_r || (sync_data != last_val_r);
    end else begin
      wr_req_s = 1'b0;
    end
    full_s  = (level_r == LVL_FULL);
    empty_s = (level_r == LVL_ZERO);
    // A pop needs a presented word, so an empty FIFO can never pop.
    pop_s   = !empty_s && out_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    wr_en_s = wr_req_s && (!full_s || pop_s);
    drop_s  = wr_req_s && full_s && !pop_s;
  end

  // FIFO bookkeeping: next pointers, next level and the word that will sit at
  // the head after this edge, so out_data can be registered.
  always_comb begin
    rd_ptr_next_s = rd_ptr_r;
    wr_ptr_next_s = wr_ptr_r;
    level_next_s  = level_r;
    head_next_s   = {S{1'b0}};

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    if (wr_en_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    case ({wr_en_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase

    // The incoming word lands on the head slot only when it becomes the sole
    // entry (empty FIFO, or last entry popped on the same edge).
    if (level_next_s == LVL_ZERO) begin
      head_next_s = {S{1'b0}};
    end else if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = sync_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Sticky overflow: a drop on this edge wins over a clear request.
  always_comb begin
    overflow_next_s = overflow_r;
    if (drop_s) begin
      overflow_next_s = 1'b1;
    end else if (clear_overflow) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // Sampler and dedup registers; reset forgets any partial qualification.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_r      <= {S{1'b0}};
      run_r       <= {RUN_W{1'b0}};
      have_last_r <= 1'b0;
      last_val_r  <= {S{1'b0}};
    end else begin
      prev_r <= sync_data;
      run_r  <= run_next_s;
      // A dropped word leaves last_val alone so it can be offered again.
      if (wr_en_s) begin
        have_last_r <= 1'b1;
        last_val_r  <= sync_data;
      end
    end
  end

  // FIFO storage; cleared on reset so no stale word can ever reach the head.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {S{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= sync_data;
    end
  end

  // FIFO pointers, level and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      level_r      <= LVL_ZERO;
      out_data_r   <= {S{1'b0}};
      out_valid_r  <= 1'b0;
      overflow_r   <= 1'b0;
      word_count_r <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_r    <= rd_ptr_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      level_r     <= level_next_s;
      out_data_r  <= head_next_s;
      out_valid_r <= (level_next_s != LVL_ZERO);
      overflow_r  <= overflow_next_s;
      if (wr_en_s) begin
        word_count_r <= word_count_r + CNT_ONE;
      end
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign overflow   = overflow_r;
  assign word_count = word_count_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_sync_word_qualifier.sv
// Directed bench for sync_word_qualifier (S=12, STABLE_CYCLES=2, DEPTH=4).
// Words expected to reach the consumer are queued as they are driven and are
// checked in order whenever the DUT hands one over.
module tb_sync_word_qualifier;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] sync_data;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clear_overflow;
  logic        overflow;
  logic [15:0] word_count;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  int exp_wc = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_w;

  sync_word_qualifier #(
    .S(12), .STABLE_CYCLES(2), .DEPTH(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sync_data(sync_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .clear_overflow(clear_overflow),
    .overflow(overflow),
    .word_count(word_count),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: a word accepted at the coming edge must match the queue head.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_word observed=%0h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        total++;
        assert (out_data === exp_w) else begin
          bad++;
          $error("FAIL word_order observed=%0h expected=%0h", out_data, exp_w);
        end
      end
    end
  end

  initial begin
    // Reset and first-word latency.
    reset_n        = 1'b0;
    sync_data      = 12'h5A5;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    tick(1);
    check("rst_valid_e1", {31'd0, out_valid}, 32'd0);
    tick(2);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {20'd0, out_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_wc", {16'd0, word_count}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);

    reset_n = 1'b1;
    exp_q.push_back(12'h5A5);
    exp_wc++;
    tick(2);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data", {20'd0, out_data}, 32'h5A5);
    check("lat_wc", {16'd0, word_count}, exp_wc);
    check("lat_level", {29'd0, fifo_level}, 32'd1);
    out_ready = 1'b1;
    tick(3);
    check("lat_drained", {29'd0, fifo_level}, 32'd0);

    // Glitch reject: a value seen for only two edges never qualifies.
    sync_data = 12'h123;
    tick(2);
    sync_data = 12'h124;
    exp_q.push_back(12'h124);
    exp_wc++;
    tick(5);
    check("glitch_wc", {16'd0, word_count}, exp_wc);

    // Dedup: a long hold enqueues once; a return to an older value re-enqueues.
    sync_data = 12'h0AA;
    exp_q.push_back(12'h0AA);
    exp_wc++;
    tick(20);
    sync_data = 12'h0AB;
    exp_q.push_back(12'h0AB);
    exp_wc++;
    tick(5);
    sync_data = 12'h0AA;
    exp_q.push_back(12'h0AA);
    exp_wc++;
    tick(5);
    check("dedup_wc", {16'd0, word_count}, exp_wc);
    check("dedup_empty", exp_q.size(), 32'd0);

    // Overflow: five words into four slots with the consumer stalled.
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      sync_data = 12'(v);
      exp_q.push_back(12'(v));
      exp_wc++;
      tick(4);
    end
    check("full_level", {29'd0, fifo_level}, 32'd4);
    check("full_no_ovf", {31'd0, overflow}, 32'd0);
    sync_data = 12'h005;
    tick(4);
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_wc", {16'd0, word_count}, exp_wc);

    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with a pop on the qualify edge: the write is taken.
    sync_data = 12'h006;
    exp_q.push_back(12'h006);
    exp_wc++;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("fullpop_level", {29'd0, fifo_level}, 32'd4);
    check("fullpop_ovf", {31'd0, overflow}, 32'd0);
    check("fullpop_head", {20'd0, out_data}, 32'h002);
    check("fullpop_wc", {16'd0, word_count}, exp_wc);

    // Drop coinciding with clear_overflow: the set wins.
    sync_data = 12'h007;
    tick(2);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("clr_prio_ovf", {31'd0, overflow}, 32'd1);
    check("clr_prio_level", {29'd0, fifo_level}, 32'd4);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("clr_after", {31'd0, overflow}, 32'd0);

    // Drain 2,3,4,6 in order.
    out_ready = 1'b1;
    tick(6);
    out_ready = 1'b0;
    check("drain_level", {29'd0, fifo_level}, 32'd0);
    check("drain_empty", exp_q.size(), 32'd0);

    // Reset mid-operation with two words queued and last_val=0x3C3.
    sync_data = 12'h3C2;
    tick(4);
    sync_data = 12'h3C3;
    tick(4);
    check("pre_rst_level", {29'd0, fifo_level}, 32'd2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_wc", {16'd0, word_count}, 32'd0);
    exp_wc = 1;
    exp_q.push_back(12'h3C3);
    tick(3);
    check("re_enq_wc", {16'd0, word_count}, exp_wc);
    check("re_enq_level", {29'd0, fifo_level}, 32'd1);
    check("re_enq_data", {20'd0, out_data}, 32'h3C3);
    out_ready = 1'b1;
    tick(2);
    check("final_empty", exp_q.size(), 32'd0);
    check("final_level", {29'd0, fifo_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
